// File: rtl/ps2_pkg.sv
// Shared constants, event layout and FSM encoding for the PS/2 Set-2 scan decoder.
package ps2_pkg;

   localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PFX_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_FAKE_SHIFT = 8'h12;
   localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;

   // Bytes of the E1 Pause sequence that follow the E1 prefix itself.
   localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;

   localparam int PS2_EVT_W = 11;

   typedef struct packed {
      logic       pause;
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } ps2_event_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_SKIP
   } ps2_state_t;

   // Keyboard housekeeping replies (ACK, BAT result, echo, errors) never become key events.
   function automatic logic ps2_is_filtered(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous event FIFO; a push is accepted when full only if a pop happens in the same cycle.
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 push,
   input  logic [PS2_EVT_W-1:0] push_data,
   output logic                 full,
   input  logic                 pop,
   output logic                 empty,
   output logic [PS2_EVT_W-1:0] head
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [PS2_EVT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W:0]       count;
   logic                 do_push;
   logic                 do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 Set-2 prefix parser feeding an event FIFO with valid/ready output.
// Define PS2_DEC_TIMEOUT_EN to abandon a stalled prefix after TIMEOUT_CYCLES idle cycles.
module ps2_scan_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       received,
   input  logic [7:0] scan_code,
   output logic       event_valid,
   input  logic       event_ready,
   output logic [7:0] event_code,
   output logic       event_ext,
   output logic       event_break,
   output logic       event_pause,
   output logic       overflow,
   input  logic       overflow_clr
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("ps2_scan_decoder: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
   end

   ps2_state_t           state;
   ps2_state_t           state_nxt;
   logic [2:0]           skip_cnt;
   logic [2:0]           skip_nxt;
   logic                 push;
   ps2_event_t           push_evt;
   logic                 full;
   logic                 empty;
   logic [PS2_EVT_W-1:0] head_bits;
   ps2_event_t           head;
   logic                 timeout_hit;

`ifdef PS2_DEC_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;

   assign timeout_hit = (state != ST_IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!reset_n || received || state == ST_IDLE || timeout_hit) to_cnt <= '0;
      else                                                         to_cnt <= to_cnt + 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         skip_cnt <= '0;
      end else begin
         state    <= state_nxt;
         skip_cnt <= skip_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      skip_nxt  = skip_cnt;
      push      = 1'b0;
      push_evt  = '{pause: 1'b0, brk: 1'b0, ext: 1'b0, code: scan_code};
      if (received) begin
         case (state)
            ST_IDLE: begin
               if (scan_code == PS2_PFX_EXT)        state_nxt = ST_EXT;
               else if (scan_code == PS2_PFX_BRK)   state_nxt = ST_BRK;
               else if (scan_code == PS2_PFX_PAUSE) begin
                  state_nxt = ST_SKIP;
                  skip_nxt  = PS2_PAUSE_TAIL;
               end else if (!ps2_is_filtered(scan_code)) push = 1'b1;
            end
            ST_EXT: begin
               if (scan_code == PS2_PFX_BRK)        state_nxt = ST_EXT_BRK;
               else if (scan_code != PS2_PFX_EXT) begin
                  state_nxt    = ST_IDLE;
                  push         = (scan_code != PS2_FAKE_SHIFT);
                  push_evt.ext = 1'b1;
               end
            end
            ST_BRK: begin
               state_nxt    = ST_IDLE;
               push         = (scan_code != PS2_PFX_EXT) && (scan_code != PS2_PFX_BRK);
               push_evt.brk = 1'b1;
            end
            ST_EXT_BRK: begin
               // A repeated prefix here is a protocol error, dropped like the fake shift.
               state_nxt    = ST_IDLE;
               push         = (scan_code != PS2_FAKE_SHIFT) && (scan_code != PS2_PFX_EXT)
                              && (scan_code != PS2_PFX_BRK);
               push_evt.ext = 1'b1;
               push_evt.brk = 1'b1;
            end
            ST_SKIP: begin
               if (skip_cnt == 3'd1) begin
                  state_nxt = ST_IDLE;
                  push      = 1'b1;
                  push_evt  = '{pause: 1'b1, brk: 1'b0, ext: 1'b0, code: PS2_PAUSE_CODE};
               end
               skip_nxt = skip_cnt - 3'd1;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end else if (timeout_hit) begin
         state_nxt = ST_IDLE;
      end
   end

   ps2_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_evt),
      .full      (full),
      .pop       (event_ready),
      .empty     (empty),
      .head      (head_bits)
   );

   // Set wins over clear so a drop in the clearing cycle is never lost.
   always_ff @(posedge clk) begin
      if (!reset_n)                        overflow <= 1'b0;
      else if (push && full && !event_ready) overflow <= 1'b1;
      else if (overflow_clr)               overflow <= 1'b0;
   end

   assign head        = ps2_event_t'(head_bits);
   assign event_valid = !empty;
   assign event_code  = head.code;
   assign event_ext   = head.ext;
   assign event_break = head.brk;
   assign event_pause = head.pause;

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver. It consumes the receiver's single-cycle `received` pulse and its 8-bit `scan_code`.
- Parses Set-2 prefix sequences (E0 extended, F0 break, E1 Pause) into one key event per physical make or break.
- Queues events in a small FIFO with a valid/ready interface toward the game/control logic.
- Filters keyboard housekeeping bytes.

Parameters:
- FIFO_DEPTH, 4, number of queued events; power of two, minimum 2.
- TIMEOUT_CYCLES, 50_000_000, prefix-abandon timeout in clk cycles. Used only with PS2_DEC_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, same domain as the receiver.
- reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- received  input  1  one-cycle strobe: scan_code is valid.
- scan_code  input  8  raw byte from the receiver.
- event_valid  output  1  head FIFO entry is valid.
- event_ready  input  1  consumer accepts the head entry.
- event_code  output  8  final scan byte of the sequence.
- event_ext  output  1  sequence carried an E0 prefix.
- event_break  output  1  sequence carried an F0 prefix (key released).
- event_pause  output  1  event is the Pause key (E1 sequence).
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - FSM goes to IDLE; FIFO emptied; skip counter = 0.
  - event_valid=0; event_code=0; event_ext=0; event_break=0; event_pause=0; overflow=0.
  - Reset mid-sequence discards any partial prefix.
- Bytes are processed only in cycles where received=1. All other cycles leave the FSM unchanged, except for the timeout option.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> SKIP with count=7.
    - 00, AA, EE, FA, FC, FD, FE, FF -> discarded, stay IDLE.
    - Any other byte -> push {code, ext=0, brk=0, pause=0}.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> stay EXT.
    - 12 (fake shift) -> discarded, go to IDLE.
    - Other -> push {code, ext=1, brk=0}, go to IDLE.
  - BRK: any byte except E0/F0 -> push {code, 0, 1}, go to IDLE. E0 or F0 -> discarded, go to IDLE (protocol error).
  - EXT_BRK: 12 -> discarded, go to IDLE. Other -> push {code, 1, 1}, go to IDLE.
  - SKIP:
    - Each byte decrements count; content is ignored.
    - When count reaches 0 after the 7th byte: push {code=8'h77, ext=0, brk=0, pause=1}, go to IDLE.
    - Pause has no break event.
- Latency:
  - Push occurs at the same clk edge that samples received=1.
  - event_valid rises the following cycle if the FIFO was empty. No combinational bypass.
- Handshake:
  - Pop when event_valid && event_ready at a clk edge.
  - Output fields hold stable while event_valid=1 && event_ready=0.
  - event_ready while empty has no effect.
- Full FIFO:
  - A push without a simultaneous pop is dropped and sets overflow. FSM state still advances.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop when empty: push only.
- overflow_clr and a drop in the same cycle: overflow stays 1 (set wins).
- FIFO pointers are log2(FIFO_DEPTH) bits, wrap naturally; the count register is one bit wider.

Optional Feature:
- Macro: PS2_DEC_TIMEOUT_EN.
- Defined:
  - A counter runs while the FSM is in EXT, BRK, EXT_BRK or SKIP and resets on every received byte.
  - At TIMEOUT_CYCLES idle cycles the FSM returns to IDLE with no push.
  - A received byte in the timeout cycle wins: it is processed normally and the counter clears.
- Not defined: no counter logic; prefix states wait indefinitely.

Decomposition:
- Package ps2_pkg holds:
  - localparams for PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_PFX_PAUSE=8'hE1, PS2_FAKE_SHIFT=8'h12, PS2_PAUSE_CODE=8'h77.
  - The filtered-byte list.
  - The FSM state encoding.
  - The event width (11 bits: pause, break, ext, code).
- Sub-module ps2_event_fifo: synchronous FIFO with the same clk/reset_n, parameter FIFO_DEPTH, push/full/pop/empty, 11-bit data.

Test Plan:
- Bytes 1C, then F0 1C, with event_ready=1 -> two events: {1C, ext0, brk0} then {1C, ext0, brk1}. First event_valid appears 1 cycle after the 1C strobe.
- Bytes E0 75, then E0 F0 75 -> {75, ext1, brk0} then {75, ext1, brk1}. Preceding E0 12 / E0 F0 12 yields no event.
- Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {77, pause1}. A following 1C decodes normally.
- AA, FA, FE, 00 -> no event, FSM in IDLE. E0 F0 F0 -> no event, FSM in IDLE.
- event_ready=0, 5 make codes with FIFO_DEPTH=4 -> 4 events held in order, 5th dropped, overflow=1. Simultaneous push and pop while full -> no drop. overflow_clr -> 0.
- reset_n=0 for 1 cycle after E0 F0, then byte 29 -> {29, ext0, brk0}. With PS2_DEC_TIMEOUT_EN and TIMEOUT_CYCLES=100: F0, 100 idle cycles, then 29 -> {29, brk0}.
